// File: rtl/emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : emu_pkg
//  Brief    : Shared state encoding and default frame sizes for the
//             co-emulation frame sequencers.
//  Revision : 1.0  initial release
// ============================================================================
package emu_pkg;

    localparam int c_STATE_W = 4;

    localparam logic [c_STATE_W-1:0] c_RECV   = 4'd0;
    localparam logic [c_STATE_W-1:0] c_FLUSH  = 4'd1;
    localparam logic [c_STATE_W-1:0] c_LOAD   = 4'd2;
    localparam logic [c_STATE_W-1:0] c_SETTLE = 4'd3;
    localparam logic [c_STATE_W-1:0] c_DUT_HI = 4'd4;
    localparam logic [c_STATE_W-1:0] c_DUT_LO = 4'd5;
    localparam logic [c_STATE_W-1:0] c_GET    = 4'd6;
    localparam logic [c_STATE_W-1:0] c_RADDR  = 4'd7;
    localparam logic [c_STATE_W-1:0] c_RWAIT  = 4'd8;
    localparam logic [c_STATE_W-1:0] c_SEND   = 4'd9;

    localparam int c_NUM_STIM_ARRAY = 4;
    localparam int c_NUM_OUT_ARRAY  = 3;
    localparam int c_ADDR_W         = 3;
    localparam int c_DUT_CYCLES     = 1;

endpackage
`default_nettype wire

// File: rtl/emu_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : emu_frame_sequencer
//  Brief    : Host-side transactor: byte stream in -> wrapper stimulus load,
//             clk_dut burst, output readback -> byte stream out.
//  Revision : 1.0  initial release
// ============================================================================
module emu_frame_sequencer
    import emu_pkg::*;
#(
    parameter int NUM_STIM_ARRAY = c_NUM_STIM_ARRAY,
    parameter int NUM_OUT_ARRAY  = c_NUM_OUT_ARRAY,
    parameter int ADDR_W         = c_ADDR_W,
    parameter int DUT_CYCLES     = c_DUT_CYCLES
) (
    input  logic              clk_emu,
    input  logic              rst_emu,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        Din_emu,
    input  logic [7:0]        Dout_emu,
    output logic [ADDR_W-1:0] Addr_emu,
    output logic              load_emu,
    output logic              get_emu,
    output logic              clk_dut,
    output logic              busy
);

    localparam int c_DCNT_W = (DUT_CYCLES > 1) ? $clog2(DUT_CYCLES) : 1;
    localparam logic [ADDR_W-1:0]   c_SCNT_LAST = ADDR_W'(NUM_STIM_ARRAY - 1);
    localparam logic [ADDR_W-1:0]   c_RCNT_LAST = ADDR_W'(NUM_OUT_ARRAY - 1);
    localparam logic [c_DCNT_W-1:0] c_DCNT_LAST = c_DCNT_W'(DUT_CYCLES - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [ADDR_W-1:0]    r_scnt;
    logic [ADDR_W-1:0]    r_rcnt;
    logic [c_DCNT_W-1:0]  r_dcnt;

    logic [c_STATE_W-1:0] w_state_nxt;
    logic [ADDR_W-1:0]    w_scnt_nxt;
    logic [ADDR_W-1:0]    w_rcnt_nxt;
    logic [c_DCNT_W-1:0]  w_dcnt_nxt;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic [7:0]           w_din_nxt;
    logic [7:0]           w_tx_data_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_scnt_nxt    = r_scnt;
        w_rcnt_nxt    = r_rcnt;
        w_dcnt_nxt    = r_dcnt;
        w_addr_nxt    = Addr_emu;
        w_din_nxt     = Din_emu;
        w_tx_data_nxt = tx_data;
        case (r_state)
            c_RECV: begin
                if (rx_valid && rx_ready) begin
                    w_addr_nxt = r_scnt;
                    w_din_nxt  = rx_data;
                    if (r_scnt == c_SCNT_LAST) begin
                        w_scnt_nxt  = '0;
                        w_state_nxt = c_FLUSH;
                    end else begin
                        w_scnt_nxt  = r_scnt + 1'b1;
                    end
                end
            end
            c_FLUSH:  w_state_nxt = c_LOAD;
            c_LOAD:   w_state_nxt = c_SETTLE;
            c_SETTLE: w_state_nxt = c_DUT_HI;
            c_DUT_HI: w_state_nxt = c_DUT_LO;
            c_DUT_LO: begin
                if (r_dcnt == c_DCNT_LAST) begin
                    w_dcnt_nxt  = '0;
                    w_state_nxt = c_GET;
                end else begin
                    w_dcnt_nxt  = r_dcnt + 1'b1;
                    w_state_nxt = c_DUT_HI;
                end
            end
            c_GET: begin
                w_rcnt_nxt  = '0;
                w_addr_nxt  = '0;
                w_state_nxt = c_RADDR;
            end
            c_RADDR:  w_state_nxt = c_RWAIT;
            c_RWAIT: begin
                w_tx_data_nxt = Dout_emu;
                w_state_nxt   = c_SEND;
            end
            c_SEND: begin
                if (tx_valid && tx_ready) begin
                    if (r_rcnt == c_RCNT_LAST) begin
                        w_rcnt_nxt  = '0;
                        w_state_nxt = c_RECV;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + 1'b1;
                        w_addr_nxt  = r_rcnt + 1'b1;
                        w_state_nxt = c_RADDR;
                    end
                end
            end
            default:  w_state_nxt = c_RECV;
        endcase
    end

    // Strobes and handshake flags are decoded from the next state so that
    // each one is a clean register output aligned to its state.
    always_ff @(posedge clk_emu) begin
        if (rst_emu) begin
            r_state  <= c_RECV;
            r_scnt   <= '0;
            r_rcnt   <= '0;
            r_dcnt   <= '0;
            Addr_emu <= '0;
            Din_emu  <= '0;
            tx_data  <= '0;
            rx_ready <= 1'b1;
            tx_valid <= 1'b0;
            load_emu <= 1'b0;
            get_emu  <= 1'b0;
            clk_dut  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_scnt   <= w_scnt_nxt;
            r_rcnt   <= w_rcnt_nxt;
            r_dcnt   <= w_dcnt_nxt;
            Addr_emu <= w_addr_nxt;
            Din_emu  <= w_din_nxt;
            tx_data  <= w_tx_data_nxt;
            rx_ready <= (w_state_nxt == c_RECV);
            tx_valid <= (w_state_nxt == c_SEND);
            load_emu <= (w_state_nxt == c_LOAD);
            get_emu  <= (w_state_nxt == c_GET);
            clk_dut  <= (w_state_nxt == c_DUT_HI);
            busy     <= (w_state_nxt != c_RECV);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_emu_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_emu_frame_sequencer
//  Brief    : Bench for emu_frame_sequencer with a behavioural wrapper model
//             and a scoreboard of expected readback bytes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_emu_frame_sequencer;

    localparam int c_NSTIM = 4;
    localparam int c_NOUT  = 3;
    localparam int c_AW    = 3;
    localparam int c_DCYC  = 3;

    logic            clk_emu = 1'b0;
    logic            rst_emu;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [7:0]      Din_emu;
    logic [7:0]      Dout_emu;
    logic [c_AW-1:0] Addr_emu;
    logic            load_emu;
    logic            get_emu;
    logic            clk_dut;
    logic            busy;

    always #5 clk_emu = ~clk_emu;

    emu_frame_sequencer #(
        .NUM_STIM_ARRAY (c_NSTIM),
        .NUM_OUT_ARRAY  (c_NOUT),
        .ADDR_W         (c_AW),
        .DUT_CYCLES     (c_DCYC)
    ) u_dut (
        .clk_emu  (clk_emu),
        .rst_emu  (rst_emu),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .Din_emu  (Din_emu),
        .Dout_emu (Dout_emu),
        .Addr_emu (Addr_emu),
        .load_emu (load_emu),
        .get_emu  (get_emu),
        .clk_dut  (clk_dut),
        .busy     (busy)
    );

    // Wrapper model: captured outputs are the preset vector mixed with the
    // loaded stimulus, so the first test frame reads back the raw preset.
    function automatic logic [7:0] f_mix(input logic [7:0] c, input logic [7:0] x,
                                         input logic [15:0] y);
        return c ^ x ^ y[15:8] ^ y[7:0] ^ 8'h16;
    endfunction

    logic [7:0]  m_stim [8];
    logic [7:0]  m_vect [8];
    logic [7:0]  m_cap  [8];
    logic [7:0]  m_cin, m_xin;
    logic [15:0] m_yin;

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_stim[i] = 8'h00;
            m_vect[i] = 8'h00;
            m_cap[i]  = 8'h00;
        end
        m_vect[0] = 8'hA1;
        m_vect[1] = 8'hB2;
        m_vect[2] = 8'hC3;
        m_cin = 8'h00;
        m_xin = 8'h00;
        m_yin = 16'h0000;
        Dout_emu = 8'h00;
    end

    always @(posedge clk_emu) begin
        if (load_emu) begin
            m_cin <= m_stim[0];
            m_xin <= m_stim[1];
            m_yin <= {m_stim[2], m_stim[3]};
        end else if (get_emu) begin
            for (int i = 0; i < 8; i++) m_cap[i] <= m_vect[i] ^ f_mix(m_cin, m_xin, m_yin);
        end else begin
            m_stim[Addr_emu] <= Din_emu;
        end
        Dout_emu <= m_cap[Addr_emu];
    end

    // Strobe / clk_dut timing monitor, sampled mid-cycle.
    int cyc = 0;
    int mon_load_cyc = 0, mon_hi_cyc = -1, mon_get_cyc = 0, mon_txv_cyc = 0;
    int mon_rises = 0, mon_rises_at_get = 0, mon_gets = 0, mon_overlap = 0;
    bit mon_prev_dut = 1'b0, mon_txv_seen = 1'b1;

    always @(posedge clk_emu) cyc <= cyc + 1;

    always @(negedge clk_emu) begin
        if (load_emu) begin
            mon_load_cyc = cyc;
            mon_rises    = 0;
            mon_hi_cyc   = -1;
        end
        if (clk_dut && !mon_prev_dut) begin
            mon_rises++;
            if (mon_hi_cyc < 0) mon_hi_cyc = cyc;
        end
        mon_prev_dut = clk_dut;
        if (get_emu) begin
            mon_get_cyc      = cyc;
            mon_rises_at_get = mon_rises;
            mon_gets++;
            mon_txv_seen     = 1'b0;
        end
        if (tx_valid && !mon_txv_seen) begin
            mon_txv_cyc  = cyc;
            mon_txv_seen = 1'b1;
        end
        if ((load_emu && get_emu) || (load_emu && clk_dut) || (get_emu && clk_dut))
            mon_overlap++;
    end

    int n_checks = 0;
    int n_errors = 0;
    int rx_viol  = 0;
    logic [7:0] sb_q [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_emu);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!rx_ready) chk("rx_ready_timeout", rx_ready, 1);
        tick();
        rx_valid = 1'b0;
    endtask

    // Byte 0 of the frame is stim[31:24].
    task automatic send_frame(input logic [31:0] stim, input int gap);
        logic [7:0] mix;
        mix = f_mix(stim[31:24], stim[23:16], stim[15:0]);
        sb_q.push_back(8'hA1 ^ mix);
        sb_q.push_back(8'hB2 ^ mix);
        sb_q.push_back(8'hC3 ^ mix);
        for (int i = 0; i < c_NSTIM; i++) begin
            send_byte(stim[31-8*i -: 8]);
            if (i < c_NSTIM - 1) repeat (gap) tick();
        end
    endtask

    task automatic recv_frame(input int stall_idx, input int stall_len);
        logic [7:0] exp;
        rx_viol = 0;
        for (int i = 0; i < c_NOUT; i++) begin
            int guard = 0;
            while (!tx_valid && guard < 100) begin
                if (rx_ready) rx_viol++;
                tick();
                guard++;
            end
            if (!tx_valid) begin
                chk("tx_valid_timeout", tx_valid, 1);
                return;
            end
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            if (i == stall_idx) begin
                repeat (stall_len) begin
                    tick();
                    chk("stall_valid", tx_valid, 1);
                    chk("stall_data", tx_data, exp);
                end
            end
            if (rx_ready) rx_viol++;
            chk("tx_data", tx_data, exp);
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            if (i < c_NOUT - 1) chk("no_dup_valid", tx_valid, 0);
        end
        chk("rx_ready_low_in_frame", rx_viol, 0);
        chk("rx_ready_after_frame", rx_ready, 1);
        chk("busy_after_frame", busy, 0);
    endtask

    task automatic frame_checks(input logic [31:0] stim);
        chk("model_cin", m_cin, stim[31:24]);
        chk("model_xin", m_xin, stim[23:16]);
        chk("model_yin", m_yin, stim[15:0]);
        chk("dut_rises", mon_rises_at_get, c_DCYC);
        chk("strobe_overlap", mon_overlap, 0);
        chk("load_to_first_hi", mon_hi_cyc - mon_load_cyc, 2);
        chk("load_to_get", mon_get_cyc - mon_load_cyc, 2 + 2 * c_DCYC);
        chk("get_to_txvalid", mon_txv_cyc - mon_get_cyc, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int gets_before;
        rst_emu  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        repeat (3) tick();
        chk("rst_flags", {rx_ready, busy, tx_valid, load_emu, get_emu, clk_dut}, 6'b100000);
        chk("rst_addr", Addr_emu, 0);
        chk("rst_din", Din_emu, 0);
        chk("rst_txdata", tx_data, 0);
        rst_emu = 1'b0;
        tick();
        chk("idle_flags", {rx_ready, busy, tx_valid}, 3'b100);

        // Frame 1: back-to-back bytes, no stall -> raw preset.
        send_frame(32'h03050010, 0);
        recv_frame(-1, 0);
        frame_checks(32'h03050010);

        // Frame 2: gapped input, tx stall on byte 1.
        send_frame(32'h03050010, 4);
        recv_frame(1, 10);
        frame_checks(32'h03050010);

        // Reset during DUT_HI.
        for (int i = 0; i < c_NSTIM; i++) send_byte(8'h40 + 8'(i));
        guard = 0;
        while (!clk_dut && guard < 50) begin
            tick();
            guard++;
        end
        chk("reached_dut_hi", clk_dut, 1);
        gets_before = mon_gets;
        rst_emu = 1'b1;
        tick();
        chk("rst_hi_flags", {clk_dut, busy, rx_ready, load_emu, get_emu}, 5'b00100);
        rst_emu = 1'b0;
        repeat (20) tick();
        chk("no_get_after_rst", mon_gets, gets_before);
        chk("no_txvalid_after_rst", tx_valid, 0);

        // Partial frame discarded by reset.
        send_byte(8'hEE);
        send_byte(8'hDD);
        rst_emu = 1'b1;
        tick();
        rst_emu = 1'b0;
        tick();

        // Back-to-back frames with different stimulus.
        send_frame(32'h11223344, 0);
        recv_frame(-1, 0);
        frame_checks(32'h11223344);
        send_frame(32'h5A00FF01, 0);
        recv_frame(-1, 0);
        frame_checks(32'h5A00FF01);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
